// File: rtl/r5fp_square_seq_pkg.sv
// Shared encodings for the sequential R5FP square: rounding modes, status bit positions and FSM states.
package r5fp_square_seq_pkg;

    localparam logic [2:0] RND_NEAREST_EVEN = 3'd0;
    localparam logic [2:0] RND_TO_ZERO      = 3'd1;
    localparam logic [2:0] RND_UP           = 3'd2;
    localparam logic [2:0] RND_DOWN         = 3'd3;
    localparam logic [2:0] RND_FROM_ZERO    = 3'd4;

    localparam int Z_IS_ZERO = 0;
    localparam int Z_IS_INF  = 1;
    localparam int Z_INVALID = 2;
    localparam int Z_TINY    = 3;
    localparam int Z_HUGE    = 4;
    localparam int Z_INEXACT = 5;

    typedef enum logic [1:0] {IDLE, MUL, ROUND} state_t;

    // Results are never negative, so UP/FROM_ZERO both round away and DOWN truncates.
    function automatic logic round_up(input logic [2:0] rnd, input logic guard,
                                      input logic sticky, input logic lsb);
        case (rnd)
            RND_NEAREST_EVEN:        return guard & (sticky | lsb);
            RND_UP, RND_FROM_ZERO:   return guard | sticky;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/r5fp_square_seq_int_sq.sv
// Shift-add integer squarer: one multiplier bit per cycle LSB first, W cycles after strobe; no backpressure.
// complete is high during the final iteration, so p holds m*m from the following cycle on.
module r5fp_square_seq_int_sq #(
    parameter int W = 24
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           strobe,
    input  logic [W-1:0]   m,
    output logic           complete,
    output logic [2*W-1:0] p
);
    localparam int CW = $clog2(W);

    logic [W-1:0]  mcand;
    logic [W-1:0]  mplier;
    logic [CW-1:0] cnt;
    logic          busy;
    logic [W:0]    sum;

    assign sum      = {1'b0, p[2*W-1:W]} + (mplier[0] ? {1'b0, mcand} : '0);
    assign complete = busy && (cnt == CW'(W-1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            p      <= '0;
        end else if (strobe) begin
            mcand  <= m;
            mplier <= m;
            cnt    <= '0;
            busy   <= 1'b1;
            p      <= '0;
        end else if (busy) begin
            p      <= {sum, p[W-1:1]};
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (complete)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/r5fp_square_seq.sv
// Sequential FP square z=a*a: SIG_W+2 cycles for normal operands, 1 for specials;
// strobe is taken only while ready, and results hold until the next accepted strobe.
module r5fp_square_seq
    import r5fp_square_seq_pkg::*;
#(
    parameter int SIG_W = 23,
    parameter int EXP_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [SIG_W+EXP_W:0]   a_in,
    input  logic [2:0]             rnd_in,
    input  logic                   strobe,
    output logic                   ready,
    output logic                   complete,
    output logic [SIG_W+EXP_W:0]   z,
    output logic [7:0]             status
);
    localparam int N  = SIG_W + EXP_W + 1;
    localparam int W  = SIG_W + 1;
    localparam int PW = 2 * W;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS      = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX      = EW'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0]     EXP_ONES  = '1;
    localparam logic [EXP_W-1:0]     EXP_MAXF  = {{(EXP_W-1){1'b1}}, 1'b0};

    state_t               state, state_nxt;
    logic [N-2:0]         a_q;
    logic [2:0]           rnd_q;
    logic                 accept, in_normal, sq_start, sq_complete;
    logic [PW-1:0]        prod;

    assign in_normal = (a_in[N-2:SIG_W] != '0) && (a_in[N-2:SIG_W] != EXP_ONES);
    assign accept    = strobe && ready;
    assign sq_start  = accept && in_normal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = in_normal ? MUL : ROUND;
            MUL:     if (sq_complete) state_nxt = ROUND;
            ROUND:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
    end

    r5fp_square_seq_int_sq #(.W(W)) u_int_sq (
        .clk      (clk),
        .reset    (reset),
        .strobe   (sq_start),
        .m        ({1'b1, a_in[SIG_W-1:0]}),
        .complete (sq_complete),
        .p        (prod)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q   <= '0;
            rnd_q <= '0;
        end else if (accept) begin
            a_q   <= a_in[N-2:0];
            rnd_q <= rnd_in;
        end
    end

    logic [EXP_W-1:0]     exp_q;
    logic [SIG_W-1:0]     frac_q;
    logic [PW-2:0]        pn;
    logic [SIG_W-1:0]     frac_p;
    logic                 guard, sticky, inc;
    logic [SIG_W:0]       frac_r;
    logic signed [EW-1:0] e_pre, e_fin;
    logic [N-1:0]         z_nxt;
    logic [7:0]           st_nxt;

    assign exp_q  = a_q[N-2:SIG_W];
    assign frac_q = a_q[SIG_W-1:0];

    // Drop the leading one so pn starts at the first stored fraction bit.
    assign pn     = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
    assign frac_p = pn[PW-2:W];
    assign guard  = pn[W-1];
    assign sticky = |pn[W-2:0];
    assign inc    = round_up(rnd_q, guard, sticky, frac_p[0]);
    assign frac_r = {1'b0, frac_p} + {{SIG_W{1'b0}}, inc};

    assign e_pre = $signed({1'b0, exp_q, 1'b0}) - BIAS + $signed({{(EW-1){1'b0}}, prod[PW-1]});
    assign e_fin = e_pre + $signed({{(EW-1){1'b0}}, frac_r[SIG_W]});

    always_comb begin
        z_nxt  = '0;
        st_nxt = '0;
        if (exp_q == EXP_ONES) begin
            if (frac_q == '0) begin
                z_nxt              = {1'b0, EXP_ONES, {SIG_W{1'b0}}};
                st_nxt[Z_IS_INF]   = 1'b1;
            end else begin
                z_nxt              = {1'b1, EXP_ONES, {(SIG_W-1){1'b0}}, 1'b1};
                st_nxt[Z_INVALID]  = 1'b1;
            end
        end else if (exp_q == '0) begin
            st_nxt[Z_IS_ZERO] = 1'b1;
            st_nxt[Z_TINY]    = (frac_q != '0);
            st_nxt[Z_INEXACT] = (frac_q != '0);
        end else if (e_fin >= EMAX) begin
            st_nxt[Z_HUGE]    = 1'b1;
            st_nxt[Z_INEXACT] = 1'b1;
            if (rnd_q == RND_TO_ZERO || rnd_q == RND_DOWN) begin
                z_nxt = {1'b0, EXP_MAXF, {SIG_W{1'b1}}};
            end else begin
                z_nxt            = {1'b0, EXP_ONES, {SIG_W{1'b0}}};
                st_nxt[Z_IS_INF] = 1'b1;
            end
        end else if (e_fin[EW-1] || e_fin == '0) begin
            st_nxt[Z_IS_ZERO] = 1'b1;
            st_nxt[Z_TINY]    = 1'b1;
            st_nxt[Z_INEXACT] = 1'b1;
        end else begin
            z_nxt             = {1'b0, e_fin[EXP_W-1:0], frac_r[SIG_W-1:0]};
            st_nxt[Z_INEXACT] = guard | sticky;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            z        <= '0;
            status   <= '0;
            complete <= 1'b0;
        end else begin
            complete <= (state == ROUND);
            if (state == ROUND) begin
                z      <= z_nxt;
                status <= st_nxt;
            end
        end
    end

endmodule

// File: tb/tb_r5fp_square_seq.sv
// Bench for r5fp_square_seq (SIG_W=23, EXP_W=8): directed table, randomized ops against an integer model, corner sequences.
module tb_r5fp_square_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] a_in = '0;
    logic [2:0]  rnd_in = '0;
    logic        strobe = 1'b0;
    logic        ready, complete;
    logic [31:0] z;
    logic [7:0]  status;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    r5fp_square_seq dut (
        .clk      (clk),
        .reset    (reset),
        .a_in     (a_in),
        .rnd_in   (rnd_in),
        .strobe   (strobe),
        .ready    (ready),
        .complete (complete),
        .z        (z),
        .status   (status)
    );

    typedef struct {
        logic [31:0] a;
        logic [2:0]  rnd;
        logic [31:0] ez;
        logic [7:0]  es;
        int          elat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: exact integer square, then rounding by remainder versus half-ulp.
    function automatic void model(input logic [31:0] a, input logic [2:0] r,
                                  output logic [31:0] zm, output logic [7:0] sm, output int lat);
        int ex, e, sh;
        longint unsigned m, p, sig, rem, half;
        bit top, up;
        ex  = int'(a[30:23]);
        lat = 25;
        zm  = 32'h0;
        sm  = 8'h0;
        if (ex == 255) begin
            lat = 1;
            if (a[22:0] == 0) begin zm = 32'h7F800000; sm = 8'h02; end
            else              begin zm = 32'hFF800001; sm = 8'h04; end
            return;
        end
        if (ex == 0) begin
            lat = 1;
            sm  = (a[22:0] == 0) ? 8'h01 : 8'h29;
            return;
        end
        m    = {40'd0, 1'b1, a[22:0]};
        p    = m * m;
        top  = (p >= (64'd1 << 47));
        sh   = top ? 24 : 23;
        sig  = p >> sh;
        rem  = p - (sig << sh);
        half = 64'd1 << (sh - 1);
        case (r)
            3'd0:       up = (rem > half) || (rem == half && sig[0]);
            3'd2, 3'd4: up = (rem != 0);
            default:    up = 1'b0;
        endcase
        e   = 2 * ex - 127 + int'(top);
        sig = sig + longint'(up);
        if (sig == (64'd1 << 24)) begin
            sig = sig >> 1;
            e   = e + 1;
        end
        if (e >= 255) begin
            if (r == 3'd1 || r == 3'd3) begin zm = 32'h7F7FFFFF; sm = 8'h30; end
            else                        begin zm = 32'h7F800000; sm = 8'h32; end
        end else if (e <= 0) begin
            sm = 8'h29;
        end else begin
            zm = {1'b0, 8'(e), sig[22:0]};
            sm = (rem != 0) ? 8'h20 : 8'h00;
        end
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [2:0] r,
                          output logic [31:0] zo, output logic [7:0] so, output int lat);
        a_in   = a;
        rnd_in = r;
        strobe = 1'b1;
        @(posedge clk);
        #1;
        strobe = 1'b0;
        lat    = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!complete && lat < 200);
        zo = z;
        so = status;
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] zo, zm, a;
        logic [7:0]  so, sm;
        logic [2:0]  r;
        int          lat, mlat, pulses, first;

        vecs.push_back('{32'h3FC00000, 3'd0, 32'h40100000, 8'h00, 25});
        vecs.push_back('{32'hC0000000, 3'd0, 32'h40800000, 8'h00, 25});
        vecs.push_back('{32'h3F800001, 3'd0, 32'h3F800002, 8'h20, 25});
        vecs.push_back('{32'h3F800001, 3'd2, 32'h3F800003, 8'h20, 25});
        vecs.push_back('{32'h3F800001, 3'd3, 32'h3F800002, 8'h20, 25});
        vecs.push_back('{32'h3F800001, 3'd4, 32'h3F800003, 8'h20, 25});
        vecs.push_back('{32'h7F7FFFFF, 3'd0, 32'h7F800000, 8'h32, 25});
        vecs.push_back('{32'h7F7FFFFF, 3'd1, 32'h7F7FFFFF, 8'h30, 25});
        vecs.push_back('{32'h1F800000, 3'd0, 32'h00000000, 8'h29, 25});
        vecs.push_back('{32'h7F800000, 3'd0, 32'h7F800000, 8'h02, 1});
        vecs.push_back('{32'h7FC00000, 3'd0, 32'hFF800001, 8'h04, 1});
        vecs.push_back('{32'h80000000, 3'd0, 32'h00000000, 8'h01, 1});
        vecs.push_back('{32'h00000001, 3'd0, 32'h00000000, 8'h29, 1});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_complete", 32'(complete), 32'd0);
        chk("rst_z", z, 32'h0);
        chk("rst_status", 32'(status), 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].rnd, zo, so, lat);
            chk($sformatf("vec%0d_z", i), zo, vecs[i].ez);
            chk($sformatf("vec%0d_status", i), 32'(so), 32'(vecs[i].es));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].elat));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_pulse", i), {30'd0, complete, ready}, 32'd1);
        end

        // Back-to-back random operations: each strobe lands in the cycle after complete.
        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            if (i % 2 == 0) a[30:23] = 8'($urandom_range(100, 160));
            r = 3'($urandom_range(0, 4));
            model(a, r, zm, sm, mlat);
            run_op(a, r, zo, so, lat);
            chk($sformatf("rand%0d_z a=%0h r=%0d", i, a, r), zo, zm);
            chk($sformatf("rand%0d_status a=%0h r=%0d", i, a, r), 32'(so), 32'(sm));
            chk($sformatf("rand%0d_latency", i), 32'(lat), 32'(mlat));
        end
        @(posedge clk);
        #1;

        // Strobe held high through MUL with a changing operand.
        a_in   = 32'h3FC00000;
        rnd_in = 3'd0;
        strobe = 1'b1;
        pulses = 0;
        first  = -1;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) a_in = 32'h40000000;
            if (i == 20) strobe = 1'b0;
            if (complete) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        chk("held_pulses", 32'(pulses), 32'd1);
        chk("held_latency", 32'(first), 32'd25);
        chk("held_z", z, 32'h40100000);

        // Reset pulsed in the middle of MUL.
        a_in   = 32'h3FC00000;
        strobe = 1'b1;
        @(posedge clk);
        #1;
        strobe = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_complete", 32'(complete), 32'd0);
        chk("midrst_z", z, 32'h0);
        chk("midrst_status", 32'(status), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (complete) pulses++;
        end
        chk("midrst_no_stale", 32'(pulses), 32'd0);
        run_op(32'h3FC00000, 3'd0, zo, so, lat);
        chk("after_rst_z", zo, 32'h40100000);
        chk("after_rst_status", 32'(so), 32'h0);
        chk("after_rst_latency", 32'(lat), 32'd25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/r5fp_square_seq.md
R5FP_SQUARE_SEQ -- requirements
Module: R5FP_square_seq

Interface
REQ-001 SHALL have parameter SIG_W, default 23, stored fraction width.
REQ-002 SHALL have parameter EXP_W, default 8, exponent width.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-005 SHALL have port a_in, input, SIG_W+EXP_W+1, operand {sign, exp, frac}.
REQ-006 SHALL have port rnd_in, input, 3, rounding mode using the shared `RND_*` encodings.
REQ-007 SHALL have port strobe, input, 1, start request.
REQ-008 SHALL have port ready, output, 1, idle and able to accept strobe.
REQ-009 SHALL have port complete, output, 1, one-cycle result-valid pulse.
REQ-010 SHALL have port z, output, SIG_W+EXP_W+1, result a*a.
REQ-011 SHALL have port status, output, 8, flags using the shared `Z_*` bit positions.

Function
REQ-012 SHALL accept strobe only when ready=1; on that edge it registers a_in and rnd_in, drops ready, and leaves IDLE.
REQ-013 SHALL ignore strobe while ready=0.
REQ-014 SHALL implement states IDLE, MUL and ROUND: IDLE->MUL for finite nonzero normal operands; IDLE->ROUND for special operands; MUL->ROUND after exactly SIG_W+1 iterations; ROUND->IDLE unconditionally.
REQ-015 SHALL, in MUL, form P=m*m with m={1,frac}, SIG_W+1 bits; it processes one multiplier bit per cycle, LSB first, shift-add into a 2*SIG_W+2-bit accumulator.
REQ-016 SHALL compute the unbiased result exponent as 2*exp-bias+P[MSB] in EXP_W+2-bit signed arithmetic; bias=2^(EXP_W-1)-1.
REQ-017 SHALL normalise P to SIG_W+1 significant bits plus guard bit and sticky bit (OR of all lower bits).
REQ-018 SHALL round by mode: RNE uses guard&(sticky|lsb); UP and FROM_ZERO use guard|sticky; TO_ZERO and DOWN truncate. Sign is always 0. A rounding carry-out increments the exponent.
REQ-019 SHALL handle exponent >= 2^EXP_W-1 as follows: RNE/UP/FROM_ZERO give +inf with Z_IS_INF|Z_HUGE|Z_INEXACT; TO_ZERO/DOWN give max finite with Z_HUGE|Z_INEXACT.
REQ-020 SHALL handle exponent <= 0 by flushing to +0 with Z_IS_ZERO|Z_TINY|Z_INEXACT; no subnormal output.
REQ-021 SHALL map special operands as follows: ±0 gives +0 with Z_IS_ZERO; ±inf gives +inf with Z_IS_INF; NaN gives canonical NaN {1,all-ones exp,0..01} with Z_INVALID; subnormal input gives +0 with Z_IS_ZERO|Z_TINY|Z_INEXACT.
REQ-022 SHALL set Z_INEXACT whenever guard|sticky=1 for a finite result.
REQ-023 SHALL register z, status and complete=1 on the ROUND edge, and set ready=1 on that same edge.
REQ-024 SHALL give latency from the strobe-accept edge to complete high of SIG_W+2 edges for normal operands and 1 edge for special operands.
REQ-025 SHALL hold z and status stable after complete until the next accepted strobe.
REQ-026 SHALL accept a strobe in the cycle immediately after complete.

Reset
REQ-027 SHALL, while reset=0, force IDLE, ready=1, complete=0, z=0, status=0, and clear the accumulator and counter; this applies mid-operation too, with no stale complete afterwards.

Structure
REQ-028 SHALL take the rounding-mode and status-bit encodings from the shared R5FP_inc.vh; the state enum {IDLE, MUL, ROUND} SHALL live in the shared R5FP sequential package.
REQ-029 SHALL isolate the shift-add integer squarer in sub-module R5FP_int_sq (W parameter, strobe/complete handshake); normalisation, rounding and special-case muxing SHALL stay in the top module.

Verification (SIG_W=23, EXP_W=8)
REQ-030 SHALL check a_in=0x3FC00000, RNE -> z=0x40100000, status=0, complete 25 edges after accept.
REQ-031 SHALL check a_in=0xC0000000 -> z=0x40800000, status=0; and a_in=0x3F800001 -> RNE z=0x3F800002 inexact, UP z=0x3F800003 inexact.
REQ-032 SHALL check a_in=0x7F7FFFFF -> RNE z=0x7F800000 with INF|HUGE|INEXACT; TO_ZERO z=0x7F7FFFFF with HUGE|INEXACT.
REQ-033 SHALL check a_in=0x1F800000 -> z=0x00000000 with ZERO|TINY|INEXACT; a_in=0x7F800000 -> z=0x7F800000 with INF, complete 1 edge after accept; a_in=0x7FC00000 -> canonical NaN with INVALID.
REQ-034 SHALL check reset=0 pulsed mid-MUL -> ready=1, complete stays 0; a following strobe of 0x3FC00000 -> 0x40100000.
REQ-035 SHALL check strobe held high during MUL -> no restart and a single complete pulse.
